// File: rtl/pll_supervisor.sv
// PLL bring-up supervisor: pulses the PLL reset, waits for lock, then keeps
// checking the slow PLL output by counting its edges over fixed refclk windows.
module pll_supervisor #(
  parameter int RST_HOLD  = 64,
  parameter int LOCK_WAIT = 5000,
  parameter int WIN       = 1024,
  parameter int EDGE_MIN  = 120,
  parameter int EDGE_MAX  = 142
) (
  input  logic       refclk,
  input  logic       reset_n,
  input  logic       mon_clk,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       pll_ok,
  output logic [7:0] fault_count
);

  localparam int PHASE_MAX = (RST_HOLD > LOCK_WAIT) ?
                             ((RST_HOLD > WIN) ? RST_HOLD : WIN) :
                             ((LOCK_WAIT > WIN) ? LOCK_WAIT : WIN);
  localparam int PW = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
  localparam int CW = 11;

  localparam logic [PW-1:0] RST_LAST  = PW'(RST_HOLD - 1);
  localparam logic [PW-1:0] WAIT_LAST = PW'(LOCK_WAIT - 1);
  localparam logic [PW-1:0] WIN_LAST  = PW'(WIN - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] CNT_MIN_OK = CW'(EDGE_MIN);
  localparam logic [CW-1:0] CNT_MAX_OK = CW'(EDGE_MAX);

  typedef enum logic [1:0] {
    RST_PLL,
    WAIT_LOCK,
    MEASURE,
    RUN
  } state_t;

  state_t        state, next_state;
  logic [PW-1:0] phase, next_phase;
  logic [CW-1:0] edge_count, edge_base, edge_total, edge_next;
  logic          window_fail;

  logic mon_s1, mon_s2, mon_d;
  logic edge_pulse;

  // mon_clk is asynchronous: two flops for metastability, a third to find the rise.
  always_ff @(posedge refclk) begin
    if (!reset_n) begin
      mon_s1 <= 1'b0;
      mon_s2 <= 1'b0;
      mon_d  <= 1'b0;
    end else begin
      mon_s1 <= mon_clk;
      mon_s2 <= mon_s1;
      mon_d  <= mon_s2;
    end
  end

  assign edge_pulse = mon_s2 & ~mon_d;

  // NOTE: reset is sampled on the clock edge; nothing here is reset asynchronously.
  always_ff @(posedge refclk) begin
    if (!reset_n) begin
      state <= RST_PLL;
      phase <= '0;
    end else begin
      state <= next_state;
      phase <= next_phase;
    end
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    next_state  = state;
    next_phase  = phase + PW'(1);
    edge_next   = '0;
    window_fail = 1'b0;
    edge_base   = (phase == '0) ? '0 : edge_count;
    edge_total  = (edge_base == CNT_MAX) ? CNT_MAX : edge_base + CW'(edge_pulse);

    case (state)
      RST_PLL: begin
        if (phase == RST_LAST) begin
          next_state = WAIT_LOCK;
          next_phase = '0;
        end
      end
      WAIT_LOCK: begin
        if (phase == WAIT_LAST) begin
          next_state = MEASURE;
          next_phase = '0;
        end
      end
      MEASURE, RUN: begin
        edge_next = edge_total;
        if (phase == WIN_LAST) begin
          next_phase = '0;
          if (edge_total >= CNT_MIN_OK && edge_total <= CNT_MAX_OK) begin
            next_state = RUN;
          end else begin
            next_state  = RST_PLL;
            window_fail = 1'b1;
          end
        end
      end
      default: begin
        next_state = RST_PLL;
        next_phase = '0;
      end
    endcase
  end

  // Outputs are registered from next_state so they change on the same edge as the state.
  always_ff @(posedge refclk) begin
    if (!reset_n) begin
      edge_count  <= '0;
      fault_count <= '0;
      pll_reset   <= 1'b1;
      sys_rst_n   <= 1'b0;
      pll_ok      <= 1'b0;
    end else begin
      edge_count <= edge_next;
      if (window_fail && fault_count != 8'hFF) begin
        fault_count <= fault_count + 8'd1;
      end
      pll_reset <= (next_state == RST_PLL);
      sys_rst_n <= (next_state == RUN);
      pll_ok    <= (next_state == RUN);
    end
  end

endmodule

// File: tb/tb_pll_supervisor.sv
// Self-checking bench for pll_supervisor: directed scenarios plus random edge
// densities, all compared every cycle against a timeline-based reference model.
module tb_pll_supervisor;

  localparam int RST_HOLD  = 4;
  localparam int LOCK_WAIT = 8;
  localparam int WIN       = 64;
  localparam int EDGE_MIN  = 8;
  localparam int EDGE_MAX  = 12;
  localparam int ATTEMPT   = RST_HOLD + LOCK_WAIT + WIN;

  logic       refclk  = 1'b0;
  logic       reset_n = 1'b0;
  logic       mon_clk = 1'b0;
  logic       pll_reset;
  logic       sys_rst_n;
  logic       pll_ok;
  logic [7:0] fault_count;

  pll_supervisor #(
    .RST_HOLD (RST_HOLD),
    .LOCK_WAIT(LOCK_WAIT),
    .WIN      (WIN),
    .EDGE_MIN (EDGE_MIN),
    .EDGE_MAX (EDGE_MAX)
  ) dut (
    .refclk     (refclk),
    .reset_n    (reset_n),
    .mon_clk    (mon_clk),
    .pll_reset  (pll_reset),
    .sys_rst_n  (sys_rst_n),
    .pll_ok     (pll_ok),
    .fault_count(fault_count)
  );

  always #10 refclk = ~refclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // mon_clk source: 0 = stuck low, 1 = square wave of period per,
  // 2 = WIN-periodic pattern with exactly n_edges single-cycle pulses per WIN cycles.
  int mode    = 0;
  int per     = 6;
  int n_edges = 0;
  int ofs     = 0;
  int g       = 0;
  int cyc     = 0;

  function automatic logic mon_value(input int c);
    case (mode)
      1:       return ((c + ofs) % per) < (per / 2);
      2:       return (((c + ofs) * n_edges) % WIN) < n_edges;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: m_t is the cycle index inside the current bring-up attempt.
  // Attempt timeline: reset hold, lock wait, then back-to-back windows; any
  // window outside the edge range restarts the attempt. Edges reach the
  // counter two samples after mon_clk is seen high following a low sample.
  int m_t     = 0;
  int m_cnt   = 0;
  int m_fault = 0;
  bit h0, h1, h2;

  task automatic model_step(input logic rn, input logic m);
    int pos;
    bit pulse;
    if (!rn) begin
      m_t = 0; m_cnt = 0; m_fault = 0;
      h0 = 0; h1 = 0; h2 = 0;
      return;
    end
    pulse = h1 && !h2;
    h2 = h1; h1 = h0; h0 = m;
    if (m_t >= RST_HOLD + LOCK_WAIT) begin
      pos   = (m_t - RST_HOLD - LOCK_WAIT) % WIN;
      m_cnt = ((pos == 0) ? 0 : m_cnt) + int'(pulse);
      if (pos == WIN - 1 && (m_cnt < EDGE_MIN || m_cnt > EDGE_MAX)) begin
        if (m_fault < 255) m_fault++;
        m_t = 0;
        return;
      end
    end
    m_t++;
  endtask

  function automatic logic [10:0] model_out();
    logic run;
    logic [7:0] f;
    run = (m_t >= ATTEMPT);
    f   = 8'(m_fault);
    return {logic'(m_t < RST_HOLD), run, run, f};
  endfunction

  task automatic tick();
    @(posedge refclk);
    model_step(reset_n, mon_clk);
    @(negedge refclk);
    check("model", {pll_reset, sys_rst_n, pll_ok, fault_count}, model_out());
    g++;
    cyc++;
    mon_clk = mon_value(g);
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    repeat (n) tick();
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ns[4];
    int exp_pass;

    // Reset values
    mode = 0;
    do_reset(3);
    check("rst_pll_reset", pll_reset, 1);
    check("rst_sys_rst_n", sys_rst_n, 0);
    check("rst_pll_ok", pll_ok, 0);
    check("rst_fault", fault_count, 0);

    // Nominal: period 6, random phase
    mode = 1; per = 6; ofs = $urandom_range(0, 5);
    do_reset(3);
    run_to(3);            check("nom_prst_c3", pll_reset, 1);
    run_to(4);            check("nom_prst_c4", pll_reset, 0);
    run_to(ATTEMPT - 1);  check("nom_sys_c75", sys_rst_n, 0);
    run_to(ATTEMPT);      check("nom_sys_c76", sys_rst_n, 1);
                          check("nom_ok_c76", pll_ok, 1);
    run_to(ATTEMPT + 10 * WIN);
    check("nom_ok_10win", pll_ok, 1);
    check("nom_fault_10win", fault_count, 0);

    // Dead clock
    mode = 0;
    do_reset(3);
    run_to(ATTEMPT);      check("dead_f1", fault_count, 1);
                          check("dead_prst_c76", pll_reset, 1);
    run_to(ATTEMPT + 4);  check("dead_prst_c80", pll_reset, 0);
    run_to(2 * ATTEMPT);  check("dead_f2", fault_count, 2);
    run_to(3 * ATTEMPT);  check("dead_f3", fault_count, 3);
                          check("dead_sys", sys_rst_n, 0);

    // Fast clock: 32 edges per window
    mode = 2; n_edges = 32; ofs = $urandom_range(0, 63);
    do_reset(2);
    run_to(ATTEMPT);
    check("fast_fault", fault_count, 1);
    check("fast_prst", pll_reset, 1);
    check("fast_ok", pll_ok, 0);

    // Loss of clock while running, then recovery
    mode = 1; per = 6; ofs = $urandom_range(0, 5);
    do_reset(2);
    run_to(ATTEMPT);      check("loss_run", pll_ok, 1);
    mode = 0;
    run_to(ATTEMPT + WIN - 1);
    check("loss_sys_before", sys_rst_n, 1);
    check("loss_prst_before", pll_reset, 0);
    run_to(ATTEMPT + WIN);
    check("loss_sys", sys_rst_n, 0);
    check("loss_ok", pll_ok, 0);
    check("loss_prst", pll_reset, 1);
    check("loss_fault", fault_count, 1);
    mode = 1;
    run_to(2 * ATTEMPT + WIN);
    check("loss_recover_ok", pll_ok, 1);
    check("loss_recover_fault", fault_count, 1);

    // Edge-count boundaries
    ns = '{8, 12, 7, 13};
    for (int i = 0; i < 4; i++) begin
      mode = 2; n_edges = ns[i]; ofs = $urandom_range(0, 63);
      exp_pass = (ns[i] >= EDGE_MIN && ns[i] <= EDGE_MAX) ? 1 : 0;
      do_reset(2);
      run_to(ATTEMPT);
      check($sformatf("bound%0d_ok", ns[i]), pll_ok, exp_pass);
      check($sformatf("bound%0d_fault", ns[i]), fault_count, 1 - exp_pass);
      run_to(ATTEMPT + WIN);
      check($sformatf("bound%0d_ok2", ns[i]), pll_ok, exp_pass);
    end

    // Fault counter saturation, then reset in the middle of a measurement
    mode = 0;
    do_reset(2);
    run_to(255 * ATTEMPT);       check("sat_255", fault_count, 255);
    run_to(300 * ATTEMPT);       check("sat_300", fault_count, 255);
    run_to(300 * ATTEMPT + 30);  check("mid_prst", pll_reset, 0);
    do_reset(1);
    check("mid_fault_clr", fault_count, 0);
    check("mid_prst_c0", pll_reset, 1);
    run_to(3);                   check("mid_prst_c3", pll_reset, 1);
    run_to(4);                   check("mid_prst_c4", pll_reset, 0);

    // Random edge densities with occasional resets
    for (int s = 0; s < 16; s++) begin
      mode    = 2;
      n_edges = $urandom_range(0, 16);
      ofs     = $urandom_range(0, 63);
      if ($urandom_range(0, 3) == 0) do_reset($urandom_range(1, 3));
      run_to(cyc + $urandom_range(40, 400));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pll_supervisor.md
PLL_SUPERVISOR -- requirements
Module: pll_supervisor

Interface
REQ-001 SHALL have parameter RST_HOLD, default 64: number of refclk cycles that pll_reset is held high per attempt.
REQ-002 SHALL have parameter LOCK_WAIT, default 5000: settle cycles after pll_reset release before measurement starts.
REQ-003 SHALL have parameter WIN, default 1024: measurement window length in refclk cycles.
REQ-004 SHALL have parameter EDGE_MIN, default 120: minimum accepted mon_clk rising edges per window.
REQ-005 SHALL have parameter EDGE_MAX, default 142: maximum accepted mon_clk rising edges per window (nominal is 131 for 6.4 MHz at 50 MHz).
REQ-006 SHALL have port refclk, input, 1 bit: the single clock, 50 MHz.
REQ-007 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have port mon_clk, input, 1 bit: the PLL slow output clock, asynchronous to refclk and sampled as data.
REQ-009 SHALL have port pll_reset, output, 1 bit: active-high reset to the PLL pllreset pin.
REQ-010 SHALL have port sys_rst_n, output, 1 bit: active-low reset to downstream logic.
REQ-011 SHALL have port pll_ok, output, 1 bit: high while the PLL output is verified in range.
REQ-012 SHALL have port fault_count, output, 8 bits: count of failed windows.

Function
REQ-013 SHALL pass mon_clk through a 2-FF synchronizer plus one delay FF; a rising edge is sync=1 and delayed=0, giving exactly one pulse per mon_clk period.
REQ-014 SHALL implement states RST_PLL, WAIT_LOCK, MEASURE and RUN.
REQ-015 RST_PLL SHALL drive pll_reset=1 for exactly RST_HOLD cycles, then go to WAIT_LOCK.
REQ-016 WAIT_LOCK SHALL drive pll_reset=0 for exactly LOCK_WAIT cycles, then go to MEASURE.
REQ-017 In MEASURE and RUN the edge counter SHALL clear on the first cycle of each WIN-cycle window.
REQ-018 The edge counter SHALL be 11 bits wide and SHALL saturate at 2047.
REQ-019 An edge pulse on the last window cycle SHALL count toward the current window.
REQ-020 At window end, a count inside [EDGE_MIN, EDGE_MAX] inclusive SHALL count as a pass.
REQ-021 A pass in MEASURE SHALL go to RUN.
REQ-022 A pass in RUN SHALL stay in RUN and start the next window immediately, with no gap cycle.
REQ-023 A fail in MEASURE or RUN SHALL go to RST_PLL and SHALL increment fault_count, saturating at 255 (no wrap).
REQ-024 Outputs SHALL be registered: sys_rst_n=1 and pll_ok=1 only in RUN, both asserted on the first RUN cycle.
REQ-025 On leaving RUN, sys_rst_n and pll_ok SHALL deassert on the same cycle that pll_reset rises.
REQ-026 pll_reset SHALL be 1 only in RST_PLL.
REQ-027 fault_count SHALL be cleared only by reset_n.
REQ-028 State and phase counters SHALL be sized from the parameters via $clog2, with no truncation at the default values.

Reset
REQ-029 While reset_n=0 on a refclk edge, the block SHALL enter RST_PLL with its phase counter cleared.
REQ-030 While reset_n=0 on a refclk edge: pll_reset=1, sys_rst_n=0, pll_ok=0, fault_count=0, edge counter and synchronizer FFs =0.
REQ-031 Reset asserted in any state, including mid-window, SHALL abort the sequence and restart it.
REQ-032 The first RST_PLL cycle SHALL be the first cycle with reset_n=1.

Verification
(Bench parameters: RST_HOLD=4, LOCK_WAIT=8, WIN=64, EDGE_MIN=8, EDGE_MAX=12; refclk period 20 ns.)
REQ-033 Reset: reset_n low 3 cycles -> pll_reset=1, sys_rst_n=0, pll_ok=0, fault_count=0.
REQ-034 Nominal: mon_clk period 6 refclk cycles -> pll_reset high for 4 cycles after reset release; sys_rst_n=1 and pll_ok=1 from cycle 76; fault_count=0; stable for 10 windows.
REQ-035 Dead clock: mon_clk stuck 0 -> fail every 76 cycles; a 4-cycle pll_reset pulse repeats; fault_count=1,2,3 at cycles 76,152,228; sys_rst_n stays 0.
REQ-036 Fast clock: mon_clk period 2 cycles (32 edges) -> fail at first window end; fault_count=1; RST_PLL re-entered.
REQ-037 Loss in RUN: nominal until RUN, then mon_clk stopped -> at the next window end, sys_rst_n=0, pll_ok=0 and pll_reset=1 on the same cycle; fault_count=1; recovery once mon_clk restarts.
REQ-038 Boundaries: exactly 8 and exactly 12 edges per window -> pass; 7 and 13 -> fail.
REQ-039 Saturation and mid-window reset: 300 forced fails -> fault_count holds at 255; reset_n pulse mid-MEASURE -> fault_count=0 and sequence restarts at RST_PLL.
